// File: rtl/vrms_meter.sv
// Windowed RMS / mean / peak meter for a signed sample stream: exact accumulation over
// 2^LOG2_N accepted samples, then a bit-serial restoring square root publishes all results.
module vrms_meter #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 8
) (
  input  logic                     clk_fs,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     data_vld,
  input  logic signed [DATA_W-1:0] data_s,
  input  logic                     irq_ack,
  output logic        [DATA_W-1:0] v_rms,
  output logic signed [DATA_W-1:0] v_mean,
  output logic signed [DATA_W-1:0] v_max,
  output logic signed [DATA_W-1:0] v_min,
  output logic                     res_vld,
  output logic                     irq,
  output logic                     overrun
);

  localparam int SQ_W  = 2*DATA_W - 1;
  localparam int SSQ_W = SQ_W + LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int RAD_W = 2*DATA_W;
  localparam int REM_W = DATA_W + 2;
  localparam int IT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [SQ_W-1:0] floor_ms(input logic [SSQ_W-1:0] s);
    return SQ_W'(s >> LOG2_N);
  endfunction

  function automatic logic signed [DATA_W-1:0] floor_mean(input logic signed [SUM_W-1:0] s);
    return DATA_W'(s >>> LOG2_N);
  endfunction

  // One restoring step: bring down the next radicand bit pair, try (root*4+1).
  function automatic logic [REM_W+DATA_W-1:0] sqrt_step(input logic [REM_W-1:0]  rem,
                                                       input logic [DATA_W-1:0] root,
                                                       input logic [1:0]        pair);
    logic [REM_W-1:0] r;
    logic [REM_W-1:0] trial;
    r     = (rem << 2) | {{DATA_W{1'b0}}, pair};
    trial = {root, 2'b01};
    if (r >= trial) return {r - trial, (root << 1) | {{(DATA_W-1){1'b0}}, 1'b1}};
    else            return {r, root << 1};
  endfunction

  logic signed [SQ_W-1:0]   ds_sq_ext;
  logic signed [SUM_W-1:0]  ds_sum_ext;
  logic        [SQ_W-1:0]   sq;

  logic [LOG2_N-1:0]        cnt_q, cnt_d;
  logic [SSQ_W-1:0]         sum_sq_q, sum_sq_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [DATA_W-1:0] max_q, max_d, min_q, min_d;
  logic                     close_q, close_d;

  state_t                   state_q;
  logic [RAD_W-1:0]         rad_q;
  logic [REM_W-1:0]         rem_q;
  logic [DATA_W-1:0]        root_q;
  logic [IT_W-1:0]          it_q;
  logic signed [DATA_W-1:0] mean_h_q, max_h_q, min_h_q;
  logic [DATA_W-1:0]        rms_q;
  logic signed [DATA_W-1:0] mean_q, vmax_q, vmin_q;
  logic                     res_vld_q, irq_q, overrun_q;

  assign ds_sq_ext  = {{(DATA_W-1){data_s[DATA_W-1]}}, data_s};
  assign ds_sum_ext = {{LOG2_N{data_s[DATA_W-1]}}, data_s};
  assign sq         = ds_sq_ext * ds_sq_ext;

  // Window accumulation: sample 0 of each window seeds every tracker.
  always_comb begin
    cnt_d    = cnt_q;
    sum_sq_d = sum_sq_q;
    sum_d    = sum_q;
    max_d    = max_q;
    min_d    = min_q;
    close_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (data_vld) begin
      cnt_d   = cnt_q + LOG2_N'(1);
      close_d = &cnt_q;
      if (cnt_q == '0) begin
        sum_sq_d = {{LOG2_N{1'b0}}, sq};
        sum_d    = ds_sum_ext;
        max_d    = data_s;
        min_d    = data_s;
      end else begin
        sum_sq_d = sum_sq_q + {{LOG2_N{1'b0}}, sq};
        sum_d    = sum_q + ds_sum_ext;
        if (data_s > max_q) max_d = data_s;
        if (data_s < min_q) min_d = data_s;
      end
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sum_sq_q <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      close_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sum_sq_q <= sum_sq_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
      min_q    <= min_d;
      close_q  <= close_d;
    end
  end

  // Snapshot at the edge after window close, then DATA_W root steps, then publish.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      it_q      <= '0;
      mean_h_q  <= '0;
      max_h_q   <= '0;
      min_h_q   <= '0;
      rms_q     <= '0;
      mean_q    <= '0;
      vmax_q    <= '0;
      vmin_q    <= '0;
      res_vld_q <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else if (clr) begin
      state_q   <= S_IDLE;
      res_vld_q <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (irq_ack && !res_vld_q) irq_q <= 1'b0;
      if (close_q && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (close_q) begin
            rad_q    <= {1'b0, floor_ms(sum_sq_q)};
            rem_q    <= '0;
            root_q   <= '0;
            it_q     <= IT_W'(DATA_W-1);
            mean_h_q <= floor_mean(sum_q);
            max_h_q  <= max_q;
            min_h_q  <= min_q;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          {rem_q, root_q} <= sqrt_step(rem_q, root_q, rad_q[RAD_W-1:RAD_W-2]);
          rad_q           <= rad_q << 2;
          it_q            <= it_q - IT_W'(1);
          if (it_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          rms_q     <= root_q;
          mean_q    <= mean_h_q;
          vmax_q    <= max_h_q;
          vmin_q    <= min_h_q;
          res_vld_q <= 1'b1;
          irq_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign v_rms   = rms_q;
  assign v_mean  = mean_q;
  assign v_max   = vmax_q;
  assign v_min   = vmin_q;
  assign res_vld = res_vld_q;
  assign irq     = irq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_vrms_meter.sv
// Directed bench for vrms_meter: a 256-sample-window instance and an 8-sample-window
// instance that is deliberately run fast enough to overrun.
module tb_vrms_meter;
  localparam int DW = 12;

  logic clk_fs = 1'b0;
  always #5 clk_fs = ~clk_fs;

  logic                 rst_n, clr, data_vld, irq_ack;
  logic signed [DW-1:0] data_s;
  logic        [DW-1:0] v_rms;
  logic signed [DW-1:0] v_mean, v_max, v_min;
  logic                 res_vld, irq, overrun;

  logic                 b_clr, b_vld, b_ack;
  logic signed [DW-1:0] b_s;
  logic        [DW-1:0] b_rms;
  logic signed [DW-1:0] b_mean, b_max, b_min;
  logic                 b_res_vld, b_irq, b_overrun;

  int total = 0;
  int bad   = 0;

  vrms_meter #(.DATA_W(DW), .LOG2_N(8)) dut (
    .clk_fs(clk_fs), .rst_n(rst_n), .clr(clr), .data_vld(data_vld), .data_s(data_s),
    .irq_ack(irq_ack), .v_rms(v_rms), .v_mean(v_mean), .v_max(v_max), .v_min(v_min),
    .res_vld(res_vld), .irq(irq), .overrun(overrun)
  );

  vrms_meter #(.DATA_W(DW), .LOG2_N(3)) dut3 (
    .clk_fs(clk_fs), .rst_n(rst_n), .clr(b_clr), .data_vld(b_vld), .data_s(b_s),
    .irq_ack(b_ack), .v_rms(b_rms), .v_mean(b_mean), .v_max(b_max), .v_min(b_min),
    .res_vld(b_res_vld), .irq(b_irq), .overrun(b_overrun)
  );

  task automatic tick();
    @(posedge clk_fs);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic feed(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) begin
      data_vld = 1'b1;
      data_s   = (i % 2 == 0) ? DW'(a) : DW'(b);
      tick();
    end
    data_vld = 1'b0;
  endtask

  task automatic wait_res(output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (res_vld) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  initial begin
    int first, second, pulses, lat;
    rst_n = 1'b0; clr = 1'b0; data_vld = 1'b0; data_s = '0; irq_ack = 1'b0;
    b_clr = 1'b0; b_vld = 1'b0; b_s = '0; b_ack = 1'b0;
    tick(); tick();
    check("rst_rms", v_rms, 0);
    check("rst_mean", v_mean, 0);
    check("rst_max", v_max, 0);
    check("rst_min", v_min, 0);
    check("rst_res_vld", res_vld, 0);
    check("rst_irq", irq, 0);
    check("rst_overrun", overrun, 0);
    check("rst_b_overrun", b_overrun, 0);
    rst_n = 1'b1;
    tick();

    // Constant +100 at full rate: pulse cadence and first-result latency
    first = -1; second = -1; pulses = 0;
    data_vld = 1'b1; data_s = 100;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (res_vld) begin
        pulses++;
        if (first < 0) begin
          first = k;
          check("c100_rms", v_rms, 100);
          check("c100_mean", v_mean, 100);
          check("c100_max", v_max, 100);
          check("c100_min", v_min, 100);
          check("c100_irq", irq, 1);
        end else if (second < 0) begin
          second = k;
        end
      end
    end
    data_vld = 1'b0;
    check("c100_first_pulse", first, 270);
    check("c100_second_pulse", second, 526);
    check("c100_pulse_count", pulses, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_irq", irq, 0);
    check("clr_overrun", overrun, 0);
    check("clr_hold_rms", v_rms, 100);

    // Square wave +-1000, with irq_ack raised during the res_vld cycle
    feed(256, 1000, -1000);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (res_vld) begin
        lat = k;
        break;
      end
    end
    check("sq_latency", lat, 14);
    check("sq_rms", v_rms, 1000);
    check("sq_mean", v_mean, 0);
    check("sq_max", v_max, 1000);
    check("sq_min", v_min, -1000);
    irq_ack = 1'b1;
    tick();
    check("ack_coincident_irq", irq, 1);
    check("ack_res_vld_drop", res_vld, 0);
    tick();
    check("ack_clears_irq", irq, 0);
    irq_ack = 1'b0;

    // Most negative sample: exact, no overflow
    feed(256, -2048, -2048);
    wait_res(lat, pulses);
    check("neg_latency", lat, 14);
    check("neg_rms", v_rms, 2048);
    check("neg_mean", v_mean, -2048);
    check("neg_max", v_max, -2048);
    check("neg_min", v_min, -2048);

    // Alternating 3,-4: floor on both sqrt and mean
    feed(256, 3, -4);
    wait_res(lat, pulses);
    check("alt_pulses", pulses, 1);
    check("alt_rms", v_rms, 3);
    check("alt_mean", v_mean, -1);
    check("alt_max", v_max, 3);
    check("alt_min", v_min, -4);

    // One accepted sample in three; held 2047 while data_vld=0 must be ignored
    for (int j = 0; j < 256; j++) begin
      data_vld = 1'b0; data_s = 2047;
      tick(); tick();
      data_vld = 1'b1; data_s = (j % 2 == 0) ? DW'(1000) : DW'(-1000);
      tick();
    end
    data_vld = 1'b0; data_s = 2047;
    wait_res(lat, pulses);
    check("gap_latency", lat, 14);
    check("gap_rms", v_rms, 1000);
    check("gap_mean", v_mean, 0);
    check("gap_max", v_max, 1000);
    check("gap_min", v_min, -1000);
    check("gap_overrun", overrun, 0);

    // Reset asserted while the square root is running
    feed(256, 100, 100);
    tick(); tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_rms", v_rms, 0);
    check("midrst_mean", v_mean, 0);
    check("midrst_max", v_max, 0);
    check("midrst_min", v_min, 0);
    check("midrst_irq", irq, 0);
    tick();
    rst_n = 1'b1;
    wait_res(lat, pulses);
    check("midrst_no_pulse", pulses, 0);
    check("midrst_res_vld", res_vld, 0);

    // 8-sample window at full rate: the second window overruns and is discarded
    first = -1; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      b_vld = (k <= 16);
      b_s   = (k <= 8) ? DW'(5) : DW'(9);
      tick();
      if (b_res_vld) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    b_vld = 1'b0;
    check("ovr_first_pulse", first, 22);
    check("ovr_pulse_count", pulses, 1);
    check("ovr_flag", b_overrun, 1);
    check("ovr_rms", b_rms, 5);
    check("ovr_mean", b_mean, 5);
    check("ovr_max", b_max, 5);
    check("ovr_min", b_min, 5);
    check("ovr_irq", b_irq, 1);

    // clr with a sample presented: sample dropped, flags cleared, results held
    b_clr = 1'b1; b_vld = 1'b1; b_s = 100;
    tick();
    b_clr = 1'b0; b_vld = 1'b0;
    check("bclr_overrun", b_overrun, 0);
    check("bclr_irq", b_irq, 0);
    check("bclr_hold_rms", b_rms, 5);
    first = -1; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      b_vld = (k <= 8);
      b_s   = 7;
      tick();
      if (b_res_vld) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    b_vld = 1'b0;
    check("bclr_first_pulse", first, 22);
    check("bclr_pulse_count", pulses, 1);
    check("bclr_rms", b_rms, 7);
    check("bclr_mean", b_mean, 7);
    check("bclr_max", b_max, 7);
    check("bclr_min", b_min, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
